// File: rtl/spike_raster_fifo_pkg.sv
// Shared word layout and packing helper for the spike raster capture FIFO.
// Word layout, MSB first: {frame_start, neuron_index, spike, zero pad}.
package spike_raster_fifo_pkg;

    localparam int unsigned DATA_W    = 16;
    localparam int unsigned FS_BIT    = DATA_W - 1;
    localparam int unsigned IDX_W_DEF = 7;
    localparam int unsigned N_CH_DEF  = 4;
    localparam int unsigned IDX_LSB   = FS_BIT - IDX_W_DEF;
    localparam int unsigned SPK_LSB   = IDX_LSB - N_CH_DEF;

    // Field offsets for an arbitrary (idx_w, n_ch) configuration
    function automatic int unsigned idx_lsb(input int unsigned idx_w);
        return FS_BIT - idx_w;
    endfunction

    function automatic int unsigned spk_lsb(input int unsigned idx_w, input int unsigned n_ch);
        return FS_BIT - idx_w - n_ch;
    endfunction

    function automatic logic [DATA_W-1:0] pack_word(
        input logic              fs,
        input logic [DATA_W-1:0] idx,
        input logic [DATA_W-1:0] spk,
        input int unsigned       idx_w,
        input int unsigned       n_ch
    );
        logic [DATA_W-1:0] w_word;
        logic [DATA_W-1:0] w_idx_m;
        logic [DATA_W-1:0] w_spk_m;
        w_idx_m = idx & ((DATA_W'(1) << idx_w) - DATA_W'(1));
        w_spk_m = spk & ((DATA_W'(1) << n_ch) - DATA_W'(1));
        w_word          = '0;
        w_word[FS_BIT]  = fs;
        w_word          = w_word | (w_idx_m << idx_lsb(idx_w));
        w_word          = w_word | (w_spk_m << spk_lsb(idx_w, n_ch));
        return w_word;
    endfunction

endpackage

// File: rtl/spike_raster_fifo_if.sv
// Capture/drain bus of the spike raster FIFO; master drives samples and pops,
// slave (the FIFO) returns data and status.
interface spike_raster_fifo_if
    import spike_raster_fifo_pkg::*;
#(
    parameter int unsigned N_CH   = 4,
    parameter int unsigned IDX_W  = 7,
    parameter int unsigned DEPTH  = 1024,
    parameter int unsigned DROP_W = 16
);
    localparam int unsigned LVL_W = $clog2(DEPTH) + 1;

    logic              sample_en;
    logic [IDX_W-1:0]  neuron_index;
    logic [N_CH-1:0]   spike;
    logic              sparse;
    logic              rd_en;
    logic              clear_flags;
    logic [DATA_W-1:0] dout;
    logic              dout_valid;
    logic              empty;
    logic              full;
    logic [LVL_W-1:0]  level;
    logic              overflow;
    logic [DROP_W-1:0] drop_cnt;

    modport master (
        output sample_en, neuron_index, spike, sparse, rd_en, clear_flags,
        input  dout, dout_valid, empty, full, level, overflow, drop_cnt
    );

    modport slave (
        input  sample_en, neuron_index, spike, sparse, rd_en, clear_flags,
        output dout, dout_valid, empty, full, level, overflow, drop_cnt
    );

endinterface

// File: rtl/spike_raster_fifo_sync_fifo_bram.sv
// Synchronous FIFO over a simple dual-port block RAM with a registered read.
// A push while full is accepted when a pop happens in the same cycle.
module sync_fifo_bram #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned DEPTH  = 1024
) (
    input  logic                       i_clk,
    input  logic                       i_reset,
    input  logic                       i_wr_en,
    input  logic [DATA_W-1:0]          i_wr_data,
    input  logic                       i_rd_en,
    output logic [DATA_W-1:0]          o_rd_data,
    output logic                       o_rd_valid,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH):0]     o_level,
    output logic                       o_wr_drop_c
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PW-1:0]     r_wr_ptr;
    logic [PW-1:0]     r_rd_ptr;
    logic [PW-1:0]     r_level;
    logic              r_full;
    logic              r_empty;
    logic [DATA_W-1:0] r_rd_data;
    logic              r_rd_valid;

    logic              w_rd_ok;
    logic              w_wr_ok;
    logic [PW-1:0]     w_wr_ptr_n;
    logic [PW-1:0]     w_rd_ptr_n;

    // Fullness is judged after the same-cycle pop; an empty FIFO never falls through
    assign w_rd_ok    = i_rd_en && !r_empty;
    assign w_wr_ok    = i_wr_en && !i_reset && (!r_full || w_rd_ok);
    assign w_wr_ptr_n = r_wr_ptr + PW'(w_wr_ok);
    assign w_rd_ptr_n = r_rd_ptr + PW'(w_rd_ok);

    always_ff @(posedge i_clk) begin
        if (w_wr_ok) begin
            r_mem[r_wr_ptr[AW-1:0]] <= i_wr_data;
        end
    end

    // Status is registered from the next-pointer values so it moves with the pointers
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_full     <= 1'b0;
            r_empty    <= 1'b1;
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            r_wr_ptr   <= w_wr_ptr_n;
            r_rd_ptr   <= w_rd_ptr_n;
            r_level    <= w_wr_ptr_n - w_rd_ptr_n;
            r_empty    <= (w_wr_ptr_n == w_rd_ptr_n);
            r_full     <= (w_wr_ptr_n[AW] != w_rd_ptr_n[AW]) &&
                          (w_wr_ptr_n[AW-1:0] == w_rd_ptr_n[AW-1:0]);
            r_rd_valid <= w_rd_ok;
            if (w_rd_ok) begin
                r_rd_data <= r_mem[r_rd_ptr[AW-1:0]];
            end
        end
    end

    assign o_rd_data   = r_rd_data;
    assign o_rd_valid  = r_rd_valid;
    assign o_full      = r_full;
    assign o_empty     = r_empty;
    assign o_level     = r_level;
    assign o_wr_drop_c = i_wr_en && !i_reset && !w_wr_ok;

endmodule

// File: rtl/spike_raster_fifo.sv
// Multi-channel spike raster capture: packs sampled spike lines with the neuron
// slot index into 16-bit words and buffers them for the host drain logic.
module spike_raster_fifo
    import spike_raster_fifo_pkg::*;
#(
    parameter int unsigned N_CH   = 4,
    parameter int unsigned IDX_W  = 7,
    parameter int unsigned DEPTH  = 1024,
    parameter int unsigned DROP_W = 16
) (
    input  logic                i_clk,
    input  logic                i_reset,
    spike_raster_fifo_if.slave  io_bus
);
    localparam int unsigned LVL_W = $clog2(DEPTH) + 1;

    if ((1 + IDX_W + N_CH) > DATA_W) begin : g_bad_width
        $error("spike_raster_fifo: 1+IDX_W+N_CH exceeds the word width");
    end
    if ((N_CH < 1) || (N_CH > 8)) begin : g_bad_nch
        $error("spike_raster_fifo: N_CH must be 1..8");
    end
    if ((DEPTH < 4) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("spike_raster_fifo: DEPTH must be a power of two >= 4");
    end

    logic              w_fs;
    logic              w_cand;
    logic              w_push;
    logic              w_drop_c;
    logic [DATA_W-1:0] w_word;
    logic [DATA_W-1:0] w_dout;
    logic              w_dout_valid;
    logic              w_full;
    logic              w_empty;
    logic [LVL_W-1:0]  w_level;

    logic              r_overflow;
    logic [DROP_W-1:0] r_drop_cnt;

    // Frame-start samples always pass the sparse filter so the host can count frames
    assign w_fs   = (io_bus.neuron_index == '0);
    assign w_cand = io_bus.sparse ? ((|io_bus.spike) || w_fs) : 1'b1;
    assign w_push = io_bus.sample_en && w_cand;
    assign w_word = pack_word(w_fs, DATA_W'(io_bus.neuron_index), DATA_W'(io_bus.spike),
                              IDX_W, N_CH);

    sync_fifo_bram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_wr_en     (w_push),
        .i_wr_data   (w_word),
        .i_rd_en     (io_bus.rd_en),
        .o_rd_data   (w_dout),
        .o_rd_valid  (w_dout_valid),
        .o_full      (w_full),
        .o_empty     (w_empty),
        .o_level     (w_level),
        .o_wr_drop_c (w_drop_c)
    );

    // A drop in the same cycle as clear_flags wins over the clear
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_overflow <= 1'b0;
            r_drop_cnt <= '0;
        end else if (w_drop_c) begin
            r_overflow <= 1'b1;
            if (io_bus.clear_flags) begin
                r_drop_cnt <= DROP_W'(1);
            end else if (r_drop_cnt != '1) begin
                r_drop_cnt <= r_drop_cnt + DROP_W'(1);
            end
        end else if (io_bus.clear_flags) begin
            r_overflow <= 1'b0;
            r_drop_cnt <= '0;
        end
    end

    assign io_bus.dout       = w_dout;
    assign io_bus.dout_valid = w_dout_valid;
    assign io_bus.empty      = w_empty;
    assign io_bus.full       = w_full;
    assign io_bus.level      = w_level;
    assign io_bus.overflow   = r_overflow;
    assign io_bus.drop_cnt   = r_drop_cnt;

endmodule

// File: tb/tb_spike_raster_fifo.sv
// Directed bench for spike_raster_fifo (N_CH=4, IDX_W=7, DEPTH=4): packing,
// sparse filter, overflow/clear, push+pop while full, pointer wrap, mid-stream reset.
module tb_spike_raster_fifo;

    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_err = 0;

    logic [15:0] q[$];
    logic [15:0] exp_word;
    int          m;
    int          k;
    int          cyc;
    bit          do_push;
    bit          do_pop;

    always #5 clk = ~clk;

    spike_raster_fifo_if #(.N_CH(4), .IDX_W(7), .DEPTH(4), .DROP_W(16)) bus_if ();

    spike_raster_fifo #(.N_CH(4), .IDX_W(7), .DEPTH(4), .DROP_W(16)) dut (
        .i_clk   (clk),
        .i_reset (rst),
        .io_bus  (bus_if)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] pk(input logic [6:0] idx, input logic [3:0] spk);
        return {(idx == 7'd0), idx, spk, 4'b0000};
    endfunction

    task automatic sample(input logic [6:0] idx, input logic [3:0] spk);
        bus_if.sample_en    = 1'b1;
        bus_if.neuron_index = idx;
        bus_if.spike        = spk;
        tick();
        bus_if.sample_en    = 1'b0;
    endtask

    task automatic pop(input string tag, input logic [15:0] exp);
        bus_if.rd_en = 1'b1;
        tick();
        bus_if.rd_en = 1'b0;
        chk({tag, "_valid"}, 32'(bus_if.dout_valid), 32'd1);
        chk(tag, 32'(bus_if.dout), 32'(exp));
    endtask

    initial begin
        rst                 = 1'b1;
        bus_if.sample_en    = 1'b0;
        bus_if.neuron_index = '0;
        bus_if.spike        = '0;
        bus_if.sparse       = 1'b0;
        bus_if.rd_en        = 1'b0;
        bus_if.clear_flags  = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        tick();

        // reset state
        chk("rst_dout",     32'(bus_if.dout),       32'h0);
        chk("rst_valid",    32'(bus_if.dout_valid), 32'd0);
        chk("rst_empty",    32'(bus_if.empty),      32'd1);
        chk("rst_full",     32'(bus_if.full),       32'd0);
        chk("rst_level",    32'(bus_if.level),      32'd0);
        chk("rst_overflow", 32'(bus_if.overflow),   32'd0);
        chk("rst_drop",     32'(bus_if.drop_cnt),   32'd0);

        // dense packing
        sample(7'd0, 4'b0101);
        sample(7'd5, 4'b0000);
        chk("t1_level", 32'(bus_if.level), 32'd2);
        pop("t1_w0", 16'h8050);
        tick();
        chk("t1_valid_drop", 32'(bus_if.dout_valid), 32'd0);
        pop("t1_w1", 16'h0500);
        chk("t1_empty", 32'(bus_if.empty), 32'd1);

        // sparse filter over one frame of 128 slots
        bus_if.sparse = 1'b1;
        for (int i = 0; i < 128; i++) begin
            sample(7'(i), (i == 3) ? 4'b0001 : 4'b0000);
        end
        chk("t2_level", 32'(bus_if.level), 32'd2);
        chk("t2_overflow", 32'(bus_if.overflow), 32'd0);
        pop("t2_w0", 16'h8000);
        pop("t2_w1", 16'h0310);
        bus_if.sparse = 1'b0;

        // overflow with no reads
        for (int i = 1; i <= 6; i++) begin
            sample(7'(i), 4'(i));
        end
        chk("t3_full",     32'(bus_if.full),     32'd1);
        chk("t3_level",    32'(bus_if.level),    32'd4);
        chk("t3_overflow", 32'(bus_if.overflow), 32'd1);
        chk("t3_drop",     32'(bus_if.drop_cnt), 32'd2);
        bus_if.clear_flags = 1'b1;
        tick();
        bus_if.clear_flags = 1'b0;
        chk("t3_clr_overflow", 32'(bus_if.overflow), 32'd0);
        chk("t3_clr_drop",     32'(bus_if.drop_cnt), 32'd0);
        chk("t3_clr_level",    32'(bus_if.level),    32'd4);

        // drop and clear in the same cycle: drop wins
        bus_if.clear_flags = 1'b1;
        sample(7'd8, 4'd8);
        bus_if.clear_flags = 1'b0;
        chk("t3b_overflow", 32'(bus_if.overflow), 32'd1);
        chk("t3b_drop",     32'(bus_if.drop_cnt), 32'd1);
        bus_if.clear_flags = 1'b1;
        tick();
        bus_if.clear_flags = 1'b0;
        chk("t3b_clr_drop", 32'(bus_if.drop_cnt), 32'd0);

        // push and pop together while full
        bus_if.sample_en    = 1'b1;
        bus_if.neuron_index = 7'd7;
        bus_if.spike        = 4'd7;
        bus_if.rd_en        = 1'b1;
        tick();
        bus_if.sample_en    = 1'b0;
        bus_if.rd_en        = 1'b0;
        chk("t4_valid",    32'(bus_if.dout_valid), 32'd1);
        chk("t4_dout",     32'(bus_if.dout),       32'h0110);
        chk("t4_level",    32'(bus_if.level),      32'd4);
        chk("t4_full",     32'(bus_if.full),       32'd1);
        chk("t4_drop",     32'(bus_if.drop_cnt),   32'd0);
        chk("t4_overflow", 32'(bus_if.overflow),   32'd0);
        pop("t4_w1", 16'h0220);
        pop("t4_w2", 16'h0330);
        pop("t4_w3", 16'h0440);
        pop("t4_w4", 16'h0770);
        chk("t4_empty", 32'(bus_if.empty), 32'd1);

        // pop while empty: ignored, dout holds
        bus_if.rd_en = 1'b1;
        tick();
        bus_if.rd_en = 1'b0;
        chk("uf_valid", 32'(bus_if.dout_valid), 32'd0);
        chk("uf_dout",  32'(bus_if.dout),       32'h0770);
        chk("uf_level", 32'(bus_if.level),      32'd0);

        // pointer wrap: 3*DEPTH+1 words, pops every other cycle
        m   = 0;
        k   = 0;
        cyc = 0;
        while ((k < 13 || m > 0) && cyc < 200) begin
            do_pop  = (cyc % 2 == 1) && (m > 0);
            do_push = (k < 13) && (m < 4 || do_pop);
            bus_if.sample_en    = do_push;
            bus_if.neuron_index = 7'(k);
            bus_if.spike        = 4'(k);
            bus_if.rd_en        = do_pop;
            if (do_pop) exp_word = q.pop_front();
            if (do_push) begin
                q.push_back(pk(7'(k), 4'(k)));
                k++;
            end
            m = m + int'(do_push) - int'(do_pop);
            tick();
            bus_if.sample_en = 1'b0;
            bus_if.rd_en     = 1'b0;
            chk("t5_valid", 32'(bus_if.dout_valid), 32'(do_pop));
            if (do_pop) chk("t5_dout", 32'(bus_if.dout), 32'(exp_word));
            chk("t5_level", 32'(bus_if.level), 32'(m));
            chk("t5_empty", 32'(bus_if.empty), 32'(m == 0));
            chk("t5_full",  32'(bus_if.full),  32'(m == 4));
            cyc++;
        end
        chk("t5_words_done", 32'(k), 32'd13);
        chk("t5_drop", 32'(bus_if.drop_cnt), 32'd0);

        // reset mid-stream with rd_en and sample_en held
        sample(7'd1, 4'd1);
        sample(7'd2, 4'd2);
        sample(7'd3, 4'd3);
        chk("t6_level_pre", 32'(bus_if.level), 32'd3);
        bus_if.rd_en        = 1'b1;
        bus_if.sample_en    = 1'b1;
        bus_if.neuron_index = 7'd10;
        bus_if.spike        = 4'd10;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus_if.sample_en = 1'b0;
        chk("t6_empty", 32'(bus_if.empty),      32'd1);
        chk("t6_level", 32'(bus_if.level),      32'd0);
        chk("t6_valid", 32'(bus_if.dout_valid), 32'd0);
        chk("t6_dout",  32'(bus_if.dout),       32'h0);
        tick();
        bus_if.rd_en = 1'b0;
        chk("t6_valid_post", 32'(bus_if.dout_valid), 32'd0);
        chk("t6_empty_post", 32'(bus_if.empty),      32'd1);
        sample(7'd12, 4'd12);
        pop("t6_w0", 16'h0CC0);
        chk("t6_empty_end", 32'(bus_if.empty), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
